// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - 4x4 tile / 3x3 kernel valid-convolution sequencer
// One shared MAC runs 9 taps x 4 output positions and returns four sums on a valid/ready handshake.
module conv_sequencer #(
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*DW-1:0]     DATA,
  input  logic [9*DW-1:0]      FILTER,
  output logic [1:0]           state,
  output logic                 busy,
  output logic                 ret_valid,
  input  logic                 ret_ready,
  output logic [4*ACC_W-1:0]   RET
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MAC  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t             cur;
  logic [DW-1:0]      d_reg [16];
  logic [DW-1:0]      f_reg [9];
  logic [3:0]         k;
  logic [1:0]         p;
  logic [ACC_W-1:0]   acc;
  logic [4*ACC_W-1:0] ret_reg;

  logic [3:0]         tap_off;
  logic [3:0]         pix_idx;
  logic [2*DW-1:0]    prod;
  logic [ACC_W-1:0]   sum;

  // Tap k maps to tile offset 4*(k/3) + k%3 relative to the window's top-left pixel.
  always_comb begin
    tap_off = 4'd0;
    case (k)
      4'd0: tap_off = 4'd0;
      4'd1: tap_off = 4'd1;
      4'd2: tap_off = 4'd2;
      4'd3: tap_off = 4'd4;
      4'd4: tap_off = 4'd5;
      4'd5: tap_off = 4'd6;
      4'd6: tap_off = 4'd8;
      4'd7: tap_off = 4'd9;
      4'd8: tap_off = 4'd10;
      default: tap_off = 4'd0;
    endcase
    pix_idx = {1'b0, p[1], 2'b00} + {3'b000, p[0]} + tap_off;
    prod    = d_reg[pix_idx] * f_reg[k];
    sum     = acc + {{(ACC_W-2*DW){1'b0}}, prod};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      busy      <= 1'b0;
      ret_valid <= 1'b0;
      k         <= 4'd0;
      p         <= 2'd0;
      acc       <= '0;
      ret_reg   <= '0;
      for (int n = 0; n < 16; n++) d_reg[n] <= '0;
      for (int m = 0; m < 9; m++)  f_reg[m] <= '0;
    end else begin
      case (cur)
        IDLE: begin
          if (start) begin
            cur  <= LOAD;
            busy <= 1'b1;
          end
        end
        LOAD: begin
          for (int n = 0; n < 16; n++) d_reg[n] <= DATA[DW*n +: DW];
          for (int m = 0; m < 9; m++)  f_reg[m] <= FILTER[DW*m +: DW];
          acc <= '0;
          k   <= 4'd0;
          p   <= 2'd0;
          cur <= MAC;
        end
        MAC: begin
          if (k == 4'd8) begin
            ret_reg[ACC_W*p +: ACC_W] <= sum;
            acc <= '0;
            k   <= 4'd0;
            p   <= p + 2'd1;
            if (p == 2'd3) begin
              cur       <= DONE;
              busy      <= 1'b0;
              ret_valid <= 1'b1;
            end
          end else begin
            acc <= sum;
            k   <= k + 4'd1;
          end
        end
        DONE: begin
          if (ret_ready) begin
            cur       <= IDLE;
            ret_valid <= 1'b0;
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;
  assign RET   = ret_reg;

endmodule
